// File: rtl/fa_delay_probe.sv
// rtl/fa_delay_probe.sv - carry-in toggle / sum-return latency probe for a full adder under test
//
// Purpose:
//   Drives carry-in of an adder with a=b=1. Each accepted start toggles cin_out once,
//   then counts clock edges until the synchronised sum equals the new carry-in.
//   At that match it also checks that the synchronised carry-out is 1. If no match
//   arrives within TIMEOUT edges, the measurement aborts with an error.
//
// Ports:
//   clk      in  1      clock
//   rst_n    in  1      asynchronous active-low reset
//   start    in  1      measurement request, sampled only in IDLE
//   sum_in   in  1      adder sum, asynchronous to clk
//   cout_in  in  1      adder carry-out, asynchronous to clk
//   cin_out  out 1      registered carry-in drive
//   busy     out 1      measurement in flight
//   done     out 1      set at completion, cleared by the next accepted start
//   err      out 1      timeout, or carry-out low at the match (valid with done)
//   latency  out CNT_W  edges from the toggle edge to the first synchronised match
module fa_delay_probe #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sum_in,
  input  logic             cout_in,
  output logic             cin_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] latency
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sum_sync;
  logic [SYNC_STAGES-1:0] cout_sync;
  logic                   sum_s;
  logic                   cout_s;
  logic                   match;

  assign sum_s  = sum_sync[SYNC_STAGES-1];
  assign cout_s = cout_sync[SYNC_STAGES-1];
  assign match  = (sum_s == cin_out);

  // Synchronisers run in every state so the measured latency includes their depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sync  <= '0;
      cout_sync <= '0;
    end else begin
      sum_sync  <= {sum_sync[SYNC_STAGES-2:0], sum_in};
      cout_sync <= {cout_sync[SYNC_STAGES-2:0], cout_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cin_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      latency <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cin_out <= ~cin_out;
            cnt     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Match wins over timeout when both happen on the same edge.
          if (match) begin
            latency <= cnt;
            err     <= ~cout_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == TIMEOUT_C) begin
            latency <= TIMEOUT_C;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            // Only advanced while staying, so cnt never wraps past TIMEOUT.
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_delay_probe.sv
// tb/tb_fa_delay_probe.sv - self-checking bench for fa_delay_probe
module tb_fa_delay_probe;

  localparam int SYNC    = 2;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 255;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sum_in;
  logic             cout_in;
  logic             cin_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] latency;

  int tests = 0;
  int fails = 0;

  // 0: direct loopback, 1: loopback through 5 flops, 2: sum tied 0
  int mode = 0;
  logic [7:0] dly;

  fa_delay_probe #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sum_in (sum_in),
    .cout_in(cout_in),
    .cin_out(cin_out),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .latency(latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly <= '0;
    else        dly <= {dly[6:0], cin_out};
  end

  always_comb begin
    case (mode)
      0:       sum_in = cin_out;
      1:       sum_in = dly[4];
      default: sum_in = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: logs every sampled input since reset; the synchronised view
  // at edge n is simply the sample taken SYNC edges earlier.
  bit sum_log[$];
  bit cout_log[$];
  bit m_cin, m_busy, m_done, m_err;
  int m_lat, m_el;

  function automatic bit seen_sum();
    int n = sum_log.size();
    return (n >= SYNC) ? sum_log[n-SYNC] : 1'b0;
  endfunction

  function automatic bit seen_cout();
    int n = cout_log.size();
    return (n >= SYNC) ? cout_log[n-SYNC] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cin  <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_lat  <= 0;
      m_el   <= 0;
      sum_log.delete();
      cout_log.delete();
    end else begin
      if (!m_busy) begin
        if (start) begin
          m_cin  <= !m_cin;
          m_busy <= 1'b1;
          m_done <= 1'b0;
          m_err  <= 1'b0;
          m_el   <= 0;
        end
      end else if (seen_sum() == m_cin) begin
        m_lat  <= m_el;
        m_err  <= !seen_cout();
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else if (m_el == TIMEOUT) begin
        m_lat  <= TIMEOUT;
        m_err  <= 1'b1;
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_el <= m_el + 1;
      end
      sum_log.push_back(sum_in);
      cout_log.push_back(cout_in);
    end
  end

  always @(negedge clk) begin
    check("cmp_cin_out", int'(cin_out), int'(m_cin));
    check("cmp_busy",    int'(busy),    int'(m_busy));
    check("cmp_done",    int'(done),    int'(m_done));
    check("cmp_err",     int'(err),     int'(m_err));
    check("cmp_latency", int'(latency), m_lat);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge right after the toggle edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin
      @(negedge clk);
      edges++;
    end
    check("done_within_bound", int'(done), 1);
  endtask

  int n;
  int bn;
  int done_cnt;
  int tog_cnt;
  logic prev_cin;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    cout_in = 1'b1;
    mode    = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cin_out", int'(cin_out), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_done",    int'(done),    0);
    check("rst_err",     int'(err),     0);
    check("rst_latency", int'(latency), 0);

    // T2: direct loopback
    do_start();
    check("t2_cin_toggled", int'(cin_out), 1);
    check("t2_busy",        int'(busy),    1);
    wait_done(20, n);
    check("t2_done_edge", n, 3);
    check("t2_latency",   int'(latency), 2);
    check("t2_err",       int'(err), 0);
    check("t2_model_lat", m_lat, 2);

    // T1: asynchronous reset in the middle of a measurement
    do_start();
    start = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_cin_out", int'(cin_out), 0);
    check("t1_busy",    int'(busy),    0);
    check("t1_done",    int'(done),    0);
    check("t1_err",     int'(err),     0);
    check("t1_latency", int'(latency), 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_rel_busy", int'(busy), 0);
    check("t1_rel_done", int'(done), 0);

    // T3: loopback delayed by 5 flops, two runs
    apply_reset();
    mode = 1;
    do_start();
    wait_done(40, n);
    check("t3_lat1", int'(latency), 7);
    check("t3_model_lat1", m_lat, 7);
    do_start();
    check("t3_done_cleared", int'(done), 0);
    wait_done(40, n);
    check("t3_lat2", int'(latency), 7);
    check("t3_cin_end", int'(cin_out), 0);

    // T4: sum tied 0 -> timeout
    mode = 2;
    apply_reset();
    do_start();
    check("t4_cin", int'(cin_out), 1);
    bn = 0;
    while (busy && bn < 400) begin
      bn++;
      @(negedge clk);
    end
    check("t4_busy_edges", bn, 256);
    check("t4_done",    int'(done), 1);
    check("t4_err",     int'(err), 1);
    check("t4_latency", int'(latency), 255);
    check("t4_model_lat", m_lat, 255);

    // T5: loopback with carry-out low
    mode    = 0;
    cout_in = 1'b0;
    apply_reset();
    repeat (3) @(negedge clk);
    do_start();
    wait_done(20, n);
    check("t5_latency", int'(latency), 2);
    check("t5_err",     int'(err), 1);
    check("t5_model_err", int'(m_err), 1);

    // T6: start held high, back-to-back runs
    cout_in = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    done_cnt = 0;
    tog_cnt  = 0;
    prev_cin = cin_out;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      if (cin_out != prev_cin) tog_cnt++;
      prev_cin = cin_out;
      @(negedge clk);
    end
    start = 1'b0;
    check("t6_done_pulses", done_cnt, 10);
    check("t6_cin_toggles", tog_cnt, 9);
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
